jk_excitation_driver: RTL
=========================

// Module: jk_excitation_driver
// PURPOSE
//  Write-side counterpart of the JK storage cells. It accepts a target state word and
//  derives per-bit J/K excitation from the inverse of the JK characteristic table.
//  It drives an internal JK register bank to that target, then checks the landed value.
//  It sits upstream of any JK-built register and emits a completion/error status.
// PARAMETERS
//  WIDTH    4   bits in the target word / JK register bank
//  CNT_W    8   width of the saturating transaction counter
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  rst        in   1        asynchronous reset, active-high
//  in_valid   in   1        target word offered
//  in_ready   out  1        block can accept a target (high only in IDLE)
//  target     in   WIDTH    desired next state of the JK bank
//  j          out  WIDTH    J excitation (nonzero only in APPLY)
//  k          out  WIDTH    K excitation (nonzero only in APPLY)
//  q          out  WIDTH    current JK bank state
//  done       out  1        one-cycle pulse when a transaction completes (CHECK)
//  err        out  1        sticky: landed q != latched target; cleared only by rst
//  flips      out  $clog2(WIDTH+1)  popcount(q ^ target) captured at accept
//  txn_cnt    out  CNT_W    completed transactions, saturates at all-ones
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
//  - Reset values: state=IDLE, q=0, j=0, k=0, done=0, err=0, flips=0, txn_cnt=0.
//    in_ready goes to 1 as soon as rst deasserts.
//  - FSM states are IDLE, APPLY and CHECK; each later state lasts exactly one cycle.
//    IDLE: in_ready=1. On in_valid&&in_ready: latch tgt_r<=target, flips<=popcount(q^target), go APPLY.
//    APPLY: j/k driven from tgt_r and q. At the clock edge q<=(j&~q)|(~k&q). Go CHECK.
//    CHECK: done=1. err<=err|(q!=tgt_r). txn_cnt++ unless saturated. Go IDLE.
//  - Latency: accept at edge N -> q updated at edge N+1 -> done high in cycle N+1..N+2.
//    Throughput is one transaction per 3 cycles.
//  - Excitation (q->t : J,K): 0->0 : 0,X ; 0->1 : 1,X ; 1->0 : X,1 ; 1->1 : X,0.
//  - Default don't-care fill is 0: j=tgt_r&~q, k=~tgt_r&q (pure set/reset form).
//  - target==q is legal: j=k=0, q holds, flips=0, done still pulses.
//  - in_valid while not in IDLE is ignored; the source must hold it until in_ready.
//  - txn_cnt saturates at 2^CNT_W-1; no wrap.
//  - j/k are forced to 0 outside APPLY, so the bank never sees stray excitation.
//  - Reset mid-operation: abort immediately to IDLE, clear q; the partial transaction is lost.
// CONFIGURATION
//  JK_TOGGLE_FILL_EN defined: don't-cares filled in toggle form, j=k=(tgt_r^q).
//    Changing bits get J=K=1 (toggle); holding bits get J=K=0.
//  JK_TOGGLE_FILL_EN undefined: set/reset fill as above. Both modes give the same q sequence.
// STRUCTURE
//  - Package jk_pkg holds:
//    - state typedef {IDLE,APPLY,CHECK};
//    - function jk_excite(q,t,toggle_fill) returning {j,k};
//    - localparam for the flips width.
//  - Sub-module jk_cell: one JK bit (clk, rst, en, j, k -> q), instantiated WIDTH times
//    with en=(state==APPLY).
//  - The top level holds the FSM, the tgt_r latch, popcount, counters and the err logic.
// TESTING
//  1. rst pulse mid-clock with q=4'hF -> q=0, in_ready=1 immediately, txn_cnt=0, err=0.
//  2. q=0, target=4'hA -> APPLY j=4'hA k=4'h0. Next cycle q=4'hA, done=1, flips=2.
//  3. q=4'hA, target=4'h5 -> default fill j=4'h5 k=4'hA. With JK_TOGGLE_FILL_EN, j=k=4'hF.
//     Either way q=4'h5 and flips=4.
//  4. target equal to current q -> j=k=0, q unchanged, done pulses, flips=0, err=0.
//  5. in_valid held high with alternating targets -> accepts exactly every 3rd cycle,
//     in_ready low in APPLY/CHECK. Run 300 txns with CNT_W=8 -> txn_cnt stops at 255.
//  6. rst asserted during APPLY -> no done pulse, q=0, next accept proceeds normally.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK excitation driver: FSM states, bank sizing
// and the inverse-characteristic (excitation) function.
package jk_pkg;

  localparam int JK_WIDTH = 4;
  localparam int FLIPS_W  = $clog2(JK_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Returns {j,k} for one bit that must go from q to t; don't-cares resolved by fill mode.
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic toggle_fill);
    logic [1:0] jk;
    if (toggle_fill) begin
      jk = {q ^ t, q ^ t};
    end else begin
      jk = {t & ~q, ~t & q};
    end
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop bit of the storage bank; updates only when enabled.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK characteristic: q+ = j&~q | ~k&q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= (j & ~q) | (~k & q);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK register bank to a requested target via derived J/K excitation.
// Define JK_TOGGLE_FILL_EN to fill don't-cares in toggle form (j=k=tgt^q).
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH = JK_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             target,
  output logic [WIDTH-1:0]             j,
  output logic [WIDTH-1:0]             k,
  output logic [WIDTH-1:0]             q,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(WIDTH+1)-1:0]   flips,
  output logic [CNT_W-1:0]             txn_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
`ifdef JK_TOGGLE_FILL_EN
  localparam logic TOGGLE_FILL = 1'b1;
`else
  localparam logic TOGGLE_FILL = 1'b0;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] j_nx, k_nx;
  logic [FW-1:0]    pop;
  logic             accept;
  logic             apply_en;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign apply_en = (state == APPLY);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: every non-IDLE state lasts exactly one cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? APPLY : IDLE;
      APPLY:   state_nx = CHECK;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Excitation and flip count, evaluated against the offered target while idle
  always_comb begin
    j_nx = '0;
    k_nx = '0;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j_nx[i], k_nx[i]} = jk_excite(q[i], target[i], TOGGLE_FILL);
      pop = pop + FW'(q[i] ^ target[i]);
    end
  end

  // j/k are registered at accept so they are live only during APPLY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_r <= '0;
      flips <= '0;
      j     <= '0;
      k     <= '0;
    end else if (accept) begin
      tgt_r <= target;
      flips <= pop;
      j     <= j_nx;
      k     <= k_nx;
    end else begin
      tgt_r <= tgt_r;
      flips <= flips;
      j     <= '0;
      k     <= '0;
    end
  end

  // Completion pulse, sticky landing check and saturating transaction count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      err     <= 1'b0;
      txn_cnt <= '0;
    end else begin
      done <= (state == APPLY);
      if (state == CHECK) begin
        err <= err | (q != tgt_r);
        if (txn_cnt != {CNT_W{1'b1}}) begin
          txn_cnt <= txn_cnt + CNT_W'(1);
        end else begin
          txn_cnt <= txn_cnt;
        end
      end else begin
        err     <= err;
        txn_cnt <= txn_cnt;
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (apply_en),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

endmodule
